uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter. Sends one 8-bit byte per frame: start bit, 8 data bits LSB first, even parity bit, one stop bit. It is the transmit end of the team's 8E1 UART link. The line format matches the on-chip UART receiver, so the two blocks can be looped back directly. It sits between a byte-producing client, which uses a valid/ready handshake, and the serial output pin.

## Interface
Parameters:
- BASE_FREQ, 50_000_000: system clock frequency in Hz.
- BAUDRATE, 115_200: line bit rate.
- CLKS_PER_BIT, BASE_FREQ/BAUDRATE (434 at defaults): clocks per bit. Integer division, truncated. Legal range is 2 or more.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- tx_valid  in  1  client has a byte on data_in.
- data_in  in  8  byte to send; sampled only on acceptance.
- tx_ready  out  1  block can accept a byte. Equals (state == IDLE).
- serial_out  out  1  UART line; idles high.
- busy  out  1  high from the cycle after acceptance through the last STOP cycle.
- done  out  1  one-cycle pulse after the stop bit completes.
- parity_out  out  1  parity bit of the byte most recently accepted.

## Operation
- Acceptance occurs on a clk edge where tx_valid && tx_ready. On that edge:
  - data_in is latched into shift_reg[7:0].
  - parity_out is set to ^data_in (even parity: the XOR of the 8 data bits plus the parity bit is 0).
  - The FSM moves to START.
- States, each lasting exactly CLKS_PER_BIT cycles unless noted:
  - IDLE: serial_out=1. Waits for acceptance.
  - START: serial_out=0.
  - DATA: serial_out=shift_reg[bit_idx], bit_idx 0..7. Lasts 8×CLKS_PER_BIT cycles. bit_idx increments at each bit boundary. Leaves after bit 7.
  - PARITY: serial_out=parity_out.
  - STOP: serial_out=1. On its final cycle the FSM goes to IDLE and done is pulsed.
- Illegal state codes go to IDLE.
- Counters:
  - clk_ctr runs 0..CLKS_PER_BIT-1 and resets to 0 at every state or bit boundary. Width is $clog2(CLKS_PER_BIT).
  - bit_idx is 3 bits and resets to 0 on entering DATA.
- tx_valid and data_in are ignored while busy. Changing data_in mid-frame has no effect on the frame in progress.
- serial_out is registered, so it is glitch-free.
- Reset (rst=0), at any time including mid-frame, immediately forces:
  - state=IDLE, serial_out=1
  - busy=0, done=0, parity_out=0
  - clk_ctr=0, bit_idx=0, shift_reg=0
- Any partially sent frame is abandoned. A receiver sees it as truncated.

## Timing
- Latency: serial_out falls in the first cycle after the acceptance edge.
- A frame lasts 11×CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle.
- The bit-n edge (n=0 is START, 1..8 are data, 9 is parity, 10 is stop) occurs n×CLKS_PER_BIT cycles after the start edge.
- done is high for exactly one cycle: the first IDLE cycle after STOP. tx_ready is also high in that cycle.
- Back-to-back transfers:
  - If tx_valid is held high, the next byte is accepted in the done cycle.
  - The next START begins one cycle later, giving a minimum inter-frame gap of 1 idle-high cycle.
  - Sustained throughput is one byte per 11×CLKS_PER_BIT+1 cycles.
- Release from reset: the first acceptance is possible on the first rising clk edge with rst=1.

## Test plan
- **Single frame, 0xA5.** Setup: override CLKS_PER_BIT=16 and pulse tx_valid. Required response:
  - Sampling serial_out at bit centres (8+16n cycles after the start edge) yields 0, then 1,0,1,0,0,1,0,1, then 0 (parity), then 1 (stop).
  - busy is high for 176 cycles.
  - done pulses once.
- **Parity sweep.** Send 0x00, 0x01, 0x7F and 0xFF. Required response: parity bits are 0, 1, 1 and 0; parity_out matches each.
- **Loopback, defaults.** Drive the receiver's serial input from serial_out and send all 256 byte values back-to-back with tx_valid held high. Required response:
  - The receiver's parallel_out equals each sent byte.
  - parity_error stays 0.
  - The inter-frame gap is exactly 1 cycle.
- **Busy handling.** Mid-frame, assert tx_valid with data_in=0x3C and toggle data_in. Required response: the current frame is unchanged and 0x3C is accepted only in the done cycle.
- **Reset mid-frame.** Assert rst=0 during DATA bit 4. Required response:
  - serial_out=1 and busy=0 immediately, with no clock edge needed.
  - done is not pulsed.
  - After release, sending 0x5A produces a correct complete frame.
- **Reset values.** Hold rst=0 with tx_valid=1. Required response: serial_out=1, tx_ready=1, busy=0, done=0, parity_out=0, and no frame starts until rst=1.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8E1 UART transmitter.
// Each frame is a start bit, 8 data bits LSB first, an even parity bit and one stop bit.
// The client hands over bytes with a valid/ready handshake.
// serial_out is driven straight from a flop, so the line never glitches.
module uart_tx #(
  parameter int BASE_FREQ    = 50_000_000,
  parameter int BAUDRATE     = 115_200,
  parameter int CLKS_PER_BIT = BASE_FREQ / BAUDRATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] data_in,
  output logic       tx_ready,
  output logic       serial_out,
  output logic       busy,
  output logic       done,
  output logic       parity_out
);

  localparam int CTR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CTR_W-1:0] clk_ctr_q, clk_ctr_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_reg_q, shift_reg_d;
  logic             parity_q, parity_d;
  logic             serial_q, serial_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end;

  assign bit_end    = (clk_ctr_q == CTR_LAST);
  assign tx_ready   = (state_q == IDLE);
  assign serial_out = serial_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign parity_out = parity_q;

  // State register: every piece of state, cleared at once when the reset is asserted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      clk_ctr_q   <= '0;
      bit_idx_q   <= '0;
      shift_reg_q <= '0;
      parity_q    <= 1'b0;
      serial_q    <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_ctr_q   <= clk_ctr_d;
      bit_idx_q   <= bit_idx_d;
      shift_reg_q <= shift_reg_d;
      parity_q    <= parity_d;
      serial_q    <= serial_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic: the bit-period counter, the data bit index, and the frame sequencing.
  always_comb begin
    state_d     = state_q;
    clk_ctr_d   = clk_ctr_q;
    bit_idx_d   = bit_idx_q;
    shift_reg_d = shift_reg_q;
    parity_d    = parity_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        clk_ctr_d = '0;
        bit_idx_d = '0;
        if (tx_valid) begin
          shift_reg_d = data_in;
          parity_d    = ^data_in;
          busy_d      = 1'b1;
          state_d     = START;
        end
      end
      START: begin
        if (bit_end) begin
          clk_ctr_d = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          clk_ctr_d = clk_ctr_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_ctr_d = '0;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = PARITY;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_ctr_d = clk_ctr_q + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          clk_ctr_d = '0;
          state_d   = STOP;
        end else begin
          clk_ctr_d = clk_ctr_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          clk_ctr_d = '0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          clk_ctr_d = clk_ctr_q + 1'b1;
        end
      end
      default: begin
        clk_ctr_d = '0;
        bit_idx_d = '0;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // Output logic: the line level for the upcoming cycle, derived from the next state.
  // This lets the output flop present it in the same cycle the state changes.
  always_comb begin
    serial_d = 1'b1;
    case (state_d)
      IDLE:    serial_d = 1'b1;
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_reg_d[bit_idx_d];
      PARITY:  serial_d = parity_d;
      STOP:    serial_d = 1'b1;
      default: serial_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx with CLKS_PER_BIT = 16.
module tb_uart_tx;

  localparam int CPB   = 16;
  localparam int FRAME = 11 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       tx_ready, serial_out, busy, done, parity_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] d;
    logic       par;
  } vec_t;

  vec_t vecs [6];

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_valid   (tx_valid),
    .data_in    (data_in),
    .tx_ready   (tx_ready),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done),
    .parity_out (parity_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present a byte and return right after the acceptance edge.
  task automatic start_frame(input logic [7:0] d);
    int waited = 0;
    @(negedge clk);
    while (!tx_ready && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    chk("ready_timeout", int'(tx_ready), 1);
    tx_valid = 1'b1;
    data_in  = d;
    @(posedge clk);
  endtask

  // Called just after an acceptance edge. Cycle c=1 is the first START cycle.
  // Cycle c=FRAME+1 is the done cycle.
  // mode 0: drop tx_valid at once.
  // mode 1: keep tx_valid high with next_d, for back-to-back frames.
  // mode 2: from c=40, assert tx_valid and toggle data_in; 0x3C is left in the done cycle.
  task automatic check_frame(input logic [7:0] d, input logic par, input int mode,
                             input logic [7:0] next_d);
    int          busy_cnt = 0;
    int          done_cnt = 0;
    int          n;
    logic [10:0] rx = '0;
    logic [10:0] exp_frame;
    exp_frame = {1'b1, par, d, 1'b0};
    for (int c = 1; c <= FRAME + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("start_latency", int'(serial_out), 0);
        chk("parity_out", int'(parity_out), int'(par));
        if (mode == 0) tx_valid = 1'b0;
        else if (mode == 1) data_in = next_d;
      end
      if (mode == 2 && c >= 40) begin
        tx_valid = 1'b1;
        data_in  = (c % 2 == 1) ? 8'h3C : 8'hC3;
      end
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (c <= FRAME && (c % CPB) == 9) begin
        n = c / CPB;
        rx[n] = serial_out;
        chk($sformatf("bit%0d_of_%02h", n, d), int'(serial_out), int'(exp_frame[n]));
      end
      if (c == 100) chk("parity_hold", int'(parity_out), int'(par));
    end
    chk("done_cycle", int'(done), 1);
    chk("gap_idle", int'(serial_out), 1);
    chk("ready_in_done", int'(tx_ready), 1);
    chk("busy_cycles", busy_cnt, FRAME);
    chk("done_pulses", done_cnt, 1);
    chk("rx_byte", int'(rx[8:1]), int'(d));
    chk("rx_parity_even", int'(^rx[9:1]), 0);
    $display("frame data=%02h par=%0d busy_cycles=%0d done_pulses=%0d rx=%02h",
             d, par, busy_cnt, done_cnt, rx[8:1]);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] nb;

    vecs[0] = '{d: 8'h00, par: 1'b0};
    vecs[1] = '{d: 8'h01, par: 1'b1};
    vecs[2] = '{d: 8'h7F, par: 1'b1};
    vecs[3] = '{d: 8'hFF, par: 1'b0};
    vecs[4] = '{d: 8'h80, par: 1'b1};
    vecs[5] = '{d: 8'h55, par: 1'b0};

    // Reset held with tx_valid high: outputs idle, no frame starts.
    rst      = 1'b0;
    tx_valid = 1'b1;
    data_in  = 8'hA5;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_serial", int'(serial_out), 1);
      chk("rst_ready", int'(tx_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_parity", int'(parity_out), 0);
    end
    $display("reset hold checked");

    // Release: 0xA5 is accepted on the first rising edge with rst=1.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    check_frame(8'hA5, 1'b0, 0, 8'h00);

    // Parity sweep and other single frames.
    for (int i = 0; i < 6; i++) begin
      start_frame(vecs[i].d);
      check_frame(vecs[i].d, vecs[i].par, 0, 8'h00);
    end

    // Busy handling: requests mid-frame are ignored until the done cycle.
    start_frame(8'h97);
    check_frame(8'h97, 1'b1, 2, 8'h00);
    check_frame(8'h3C, 1'b0, 0, 8'h00);

    // Reset during DATA bit 4.
    start_frame(8'h97);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (84) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_serial", int'(serial_out), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ready", int'(tx_ready), 1);
    chk("midrst_parity", int'(parity_out), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_done", int'(done), 0);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("postrst_done", int'(done), 0);
      chk("postrst_serial", int'(serial_out), 1);
    end
    $display("reset mid-frame checked");
    start_frame(8'h5A);
    check_frame(8'h5A, 1'b0, 0, 8'h00);

    // Back-to-back frames for all 256 bytes with tx_valid held high.
    start_frame(8'h00);
    for (int i = 0; i < 256; i++) begin
      b  = 8'(i);
      nb = 8'(i + 1);
      check_frame(b, ^b, (i < 255) ? 1 : 0, nb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
